// File: rtl/datapath_pkg.sv
// Shared constants, bus-source encoding and the C-constant helper for the
// single-bus CPU datapath.
package datapath_pkg;

  localparam int WORD   = 32;
  localparam int ZWIDTH = 64;

  // Bus source, in descending priority order.
  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_PC,
    SEL_ZLO,
    SEL_ZHI,
    SEL_MDR,
    SEL_R2,
    SEL_R3,
    SEL_LO,
    SEL_HI,
    SEL_INPORT,
    SEL_C
  } bus_sel_e;

  // IR immediate field, sign-extended from bit 18.
  function automatic logic [WORD-1:0] c_sext(input logic [18:0] imm);
    return {{13{imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/reg32.sv
// 32-bit register with load enable and asynchronous active-low clear.
// Ports:
//   clk   rising-edge clock
//   clr   async clear, active low
//   i_ld  load enable; q takes d on the next rising edge
//   i_d   data in
//   o_q   data out
module reg32
  import datapath_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            i_ld,
  input  logic [WORD-1:0] i_d,
  output logic [WORD-1:0] o_q
);

  logic [WORD-1:0] r_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath for the multicycle test CPU.
// Registers R1-R3, PC, IR, MAR, MDR, Y, Z (64-bit, as two halves), HI, LO and
// InPort all hang off one shared bus. The ALU does only PC+1 and signed 32x32
// multiply. One-hot strobes from the control unit drive one micro-step per clock.
// Ports:
//   clk, clr                  clock, async active-low reset
//   *out strobes              bus-drive selects (priority PCout highest .. Cout lowest)
//   *in strobes               register load enables from the bus
//   Read                      MDR source: 1 = MDatain, 0 = bus
//   IncPC, MUL                ALU op select (MUL wins when both set)
//   MDatain, In_port          memory read data, external input port
//   bus_out                   current bus value
//   mar_out, ir_out           MAR and IR contents
//   hi_out, lo_out            HI and LO contents
//   bus_conflict              only with DATAPATH_BUS_CONFLICT_EN: two or more
//                             out-selects asserted together
module cpu_datapath
  import datapath_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            PCout,
  input  logic            Zlowout,
  input  logic            Zhighout,
  input  logic            MDRout,
  input  logic            R2out,
  input  logic            R3out,
  input  logic            LOout,
  input  logic            HIout,
  input  logic            InPortout,
  input  logic            Cout,
  input  logic            PCin,
  input  logic            IRin,
  input  logic            MARin,
  input  logic            MDRin,
  input  logic            Yin,
  input  logic            Zin,
  input  logic            LOin,
  input  logic            HIin,
  input  logic            R1in,
  input  logic            R2in,
  input  logic            R3in,
  input  logic            Read,
  input  logic            IncPC,
  input  logic            MUL,
  input  logic [WORD-1:0] MDatain,
  input  logic [WORD-1:0] In_port,
  output logic [WORD-1:0] bus_out,
  output logic [WORD-1:0] mar_out,
  output logic [WORD-1:0] ir_out,
  output logic [WORD-1:0] hi_out,
  output logic [WORD-1:0] lo_out
`ifdef DATAPATH_BUS_CONFLICT_EN
  ,output logic           bus_conflict
`endif
);

  logic [WORD-1:0]   w_bus;
  logic [WORD-1:0]   w_pc, w_ir, w_mar, w_mdr, w_y;
  logic [WORD-1:0]   w_r2, w_r3, w_hi, w_lo, w_inport;
  logic [WORD-1:0]   w_zlo, w_zhi;
  logic [WORD-1:0]   w_mdr_d;
  logic [ZWIDTH-1:0] w_z_d;
  logic              w_zld;
  bus_sel_e          w_sel;
  // R1 has no bus driver in this datapath; it is only a load target.
  logic [WORD-1:0]   w_r1_unused;

  // ---------------- registers ----------------
  reg32 u_pc  (.clk(clk), .clr(clr), .i_ld(PCin),  .i_d(w_bus), .o_q(w_pc));
  reg32 u_ir  (.clk(clk), .clr(clr), .i_ld(IRin),  .i_d(w_bus), .o_q(w_ir));
  reg32 u_mar (.clk(clk), .clr(clr), .i_ld(MARin), .i_d(w_bus), .o_q(w_mar));
  reg32 u_y   (.clk(clk), .clr(clr), .i_ld(Yin),   .i_d(w_bus), .o_q(w_y));
  reg32 u_r1  (.clk(clk), .clr(clr), .i_ld(R1in),  .i_d(w_bus), .o_q(w_r1_unused));
  reg32 u_r2  (.clk(clk), .clr(clr), .i_ld(R2in),  .i_d(w_bus), .o_q(w_r2));
  reg32 u_r3  (.clk(clk), .clr(clr), .i_ld(R3in),  .i_d(w_bus), .o_q(w_r3));
  reg32 u_hi  (.clk(clk), .clr(clr), .i_ld(HIin),  .i_d(w_bus), .o_q(w_hi));
  reg32 u_lo  (.clk(clk), .clr(clr), .i_ld(LOin),  .i_d(w_bus), .o_q(w_lo));

  assign w_mdr_d = Read ? MDatain : w_bus;
  reg32 u_mdr (.clk(clk), .clr(clr), .i_ld(MDRin), .i_d(w_mdr_d), .o_q(w_mdr));

  // InPort samples the external port every cycle.
  reg32 u_inport (.clk(clk), .clr(clr), .i_ld(1'b1), .i_d(In_port), .o_q(w_inport));

  // Z is split into halves that load together.
  assign w_zld = Zin;
  reg32 u_zlo (.clk(clk), .clr(clr), .i_ld(w_zld), .i_d(w_z_d[WORD-1:0]),      .o_q(w_zlo));
  reg32 u_zhi (.clk(clk), .clr(clr), .i_ld(w_zld), .i_d(w_z_d[ZWIDTH-1:WORD]), .o_q(w_zhi));

  // ---------------- ALU ----------------
  // Both operands signed, so the 64-bit context sign-extends them before the multiply.
  logic signed [ZWIDTH-1:0] w_prod;
  assign w_prod = $signed(w_y) * $signed(w_bus);

  always_comb begin
    w_z_d = {{(ZWIDTH-WORD){1'b0}}, w_bus};
    if (MUL)        w_z_d = w_prod;
    else if (IncPC) w_z_d = {{(ZWIDTH-WORD){1'b0}}, w_bus + WORD'(1)};
  end

  // ---------------- bus ----------------
  always_comb begin
    w_sel = SEL_NONE;
    if      (PCout)     w_sel = SEL_PC;
    else if (Zlowout)   w_sel = SEL_ZLO;
    else if (Zhighout)  w_sel = SEL_ZHI;
    else if (MDRout)    w_sel = SEL_MDR;
    else if (R2out)     w_sel = SEL_R2;
    else if (R3out)     w_sel = SEL_R3;
    else if (LOout)     w_sel = SEL_LO;
    else if (HIout)     w_sel = SEL_HI;
    else if (InPortout) w_sel = SEL_INPORT;
    else if (Cout)      w_sel = SEL_C;
  end

  always_comb begin
    w_bus = '0;
    case (w_sel)
      SEL_PC:     w_bus = w_pc;
      SEL_ZLO:    w_bus = w_zlo;
      SEL_ZHI:    w_bus = w_zhi;
      SEL_MDR:    w_bus = w_mdr;
      SEL_R2:     w_bus = w_r2;
      SEL_R3:     w_bus = w_r3;
      SEL_LO:     w_bus = w_lo;
      SEL_HI:     w_bus = w_hi;
      SEL_INPORT: w_bus = w_inport;
      SEL_C:      w_bus = c_sext(w_ir[18:0]);
      default:    w_bus = '0;
    endcase
  end

`ifdef DATAPATH_BUS_CONFLICT_EN
  logic [9:0] w_outsel;
  assign w_outsel = {PCout, Zlowout, Zhighout, MDRout, R2out,
                     R3out, LOout, HIout, InPortout, Cout};
  assign bus_conflict = ($countones(w_outsel) > 1);
`endif

  assign bus_out = w_bus;
  assign mar_out = w_mar;
  assign ir_out  = w_ir;
  assign hi_out  = w_hi;
  assign lo_out  = w_lo;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  logic clk = 1'b0;
  logic clr;
  logic PCout, Zlowout, Zhighout, MDRout, R2out, R3out, LOout, HIout, InPortout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, R1in, R2in, R3in;
  logic Read, IncPC, MUL;
  logic [31:0] MDatain, In_port;
  logic [31:0] bus_out, mar_out, ir_out, hi_out, lo_out;
`ifdef DATAPATH_BUS_CONFLICT_EN
  logic bus_conflict;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out), .LOout(LOout), .HIout(HIout),
    .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .LOin(LOin), .HIin(HIin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .Read(Read), .IncPC(IncPC), .MUL(MUL),
    .MDatain(MDatain), .In_port(In_port),
    .bus_out(bus_out), .mar_out(mar_out), .ir_out(ir_out),
    .hi_out(hi_out), .lo_out(lo_out)
`ifdef DATAPATH_BUS_CONFLICT_EN
    ,.bus_conflict(bus_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {PCout, Zlowout, Zhighout, MDRout, R2out, R3out, LOout, HIout, InPortout, Cout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, R1in, R2in, R3in} = '0;
    {Read, IncPC, MUL} = '0;
  endtask

  // Apply the strobes already set for one clock, then drop them.
  task automatic cyc();
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic mem_to_r2(input logic [31:0] v);
    MDatain = v; Read = 1; MDRin = 1; cyc();
    MDRout = 1; R2in = 1; cyc();
  endtask

  task automatic mem_to_r3(input logic [31:0] v);
    MDatain = v; Read = 1; MDRin = 1; cyc();
    MDRout = 1; R3in = 1; cyc();
  endtask

  // LO/HI <= R2 * R3
  task automatic do_mul();
    R2out = 1; Yin = 1; cyc();
    R3out = 1; MUL = 1; Zin = 1; cyc();
    Zlowout = 1; LOin = 1; cyc();
    Zhighout = 1; HIin = 1; cyc();
  endtask

  initial begin
    idle();
    MDatain = 32'h0; In_port = 32'h0;
    clr = 1'b1;
    #2;

    // 1 Reset with every enable high: loads are ignored while clr is low.
    {PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, R1in, R2in, R3in} = '1;
    PCout = 1; Read = 1; IncPC = 1; MDatain = 32'hDEAD_BEEF; In_port = 32'h1234_5678;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("rst_bus", bus_out, 32'h0);
    chk("rst_mar", mar_out, 32'h0);
    chk("rst_ir",  ir_out,  32'h0);
    chk("rst_hi",  hi_out,  32'h0);
    chk("rst_lo",  lo_out,  32'h0);
    @(negedge clk);
    idle(); MDatain = 0; In_port = 0;
    clr = 1'b1;
    #1;
    chk("post_rst_bus", bus_out, 32'h0);
    chk("post_rst_lo",  lo_out,  32'h0);
    InPortout = 1; #1;
    chk("rst_inport", bus_out, 32'h0);
    idle();

    // 2 4 * 5
    mem_to_r2(32'd4);
    mem_to_r3(32'd5);
    do_mul();
    chk("mul_lo", lo_out, 32'h0000_0014);
    chk("mul_hi", hi_out, 32'h0000_0000);

    // 3 -3 * 7
    mem_to_r2(32'hFFFF_FFFD);
    mem_to_r3(32'd7);
    do_mul();
    chk("smul_lo", lo_out, 32'hFFFF_FFEB);
    chk("smul_hi", hi_out, 32'hFFFF_FFFF);

    // MUL boundary: most-negative squared
    mem_to_r2(32'h8000_0000);
    mem_to_r3(32'h8000_0000);
    do_mul();
    chk("mulmin_lo", lo_out, 32'h0000_0000);
    chk("mulmin_hi", hi_out, 32'h4000_0000);

    // 4 Fetch
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; cyc();
    chk("fetch_mar", mar_out, 32'h0);
    Zlowout = 1; PCin = 1; MDatain = 32'h2891_8000; Read = 1; MDRin = 1; cyc();
    MDRout = 1; IRin = 1; cyc();
    chk("fetch_ir", ir_out, 32'h2891_8000);
    PCout = 1; #1;
    chk("fetch_pc", bus_out, 32'h0000_0001);
    idle();

    // 5 Constant sign extension
    Cout = 1; #1;
    chk("c_pos", bus_out, 32'h0001_8000);
    idle();
    MDatain = 32'h0004_0000; Read = 1; MDRin = 1; cyc();
    MDRout = 1; IRin = 1; cyc();
    Cout = 1; #1;
    chk("c_neg", bus_out, 32'hFFFC_0000);
    idle();

    // 6 Priority: R2 still holds 0x80000000, PC is 1
    PCout = 1; R2out = 1; #1;
    chk("prio_pc_r2", bus_out, 32'h0000_0001);
`ifdef DATAPATH_BUS_CONFLICT_EN
    chk("conflict_hi", {31'b0, bus_conflict}, 32'h1);
`endif
    idle(); #1;
    MDRout = 1; R2out = 1; #1;
    chk("prio_mdr_r2", bus_out, 32'h0004_0000);
    idle(); #1;
`ifdef DATAPATH_BUS_CONFLICT_EN
    R2out = 1; #1;
    chk("conflict_lo", {31'b0, bus_conflict}, 32'h0);
    idle(); #1;
`endif

    // PC+1 wraparound
    MDatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1; cyc();
    MDRout = 1; PCin = 1; cyc();
    PCout = 1; IncPC = 1; Zin = 1; cyc();
    Zlowout = 1; #1;
    chk("wrap_zlo", bus_out, 32'h0);
    idle(); Zhighout = 1; #1;
    chk("wrap_zhi", bus_out, 32'h0);
    idle();

    // Read=0: MDR loads from the bus; same-cycle read/write uses the pre-edge value
    PCout = 1; MDRin = 1; cyc();
    MDRout = 1; #1;
    chk("mdr_from_bus", bus_out, 32'hFFFF_FFFF);
    idle();
    Zlowout = 1; Zin = 1; IncPC = 1; cyc();   // Z <= 0 + 1
    Zlowout = 1; Zin = 1; IncPC = 1; cyc();   // Z <= 1 + 1
    Zlowout = 1; #1;
    chk("rw_same_cycle", bus_out, 32'h0000_0002);
    idle();

    // Pass-through Z (no op strobe)
    R3out = 1; Zin = 1; cyc();
    Zlowout = 1; #1;
    chk("z_pass", bus_out, 32'h8000_0000);
    idle();

    // InPort follows the port every clock
    In_port = 32'hCAFE_0042; @(posedge clk); #1;
    InPortout = 1; #1;
    chk("inport", bus_out, 32'hCAFE_0042);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
